// File: rtl/wave_capture.sv
// wave_capture: ping-pong capture of one display frame of 8-bit samples, trigger-qualified or free-running.
// Latency: rd_data registered, one pclk after rd_addr; cap_done registered, high in the first FULL cycle.
// Backpressure: none; samples are dropped outside ARM/CAPT, and a full bank waits for i_vs to swap.
//
// Ports:
//   pclk          pixel clock, the only clock
//   rst_n         asynchronous active-low reset
//   sample_data   8-bit waveform sample, qualified by sample_valid
//   sample_valid  one-cycle qualifier for sample_data
//   i_vs          vertical sync, active-high; its rising edge swaps a full bank to display
//   rd_addr       display read column
//   rd_data       display-bank sample at rd_addr (0 when out of range or nothing displayed yet)
//   cap_done      one-cycle pulse when the write bank fills
//   busy          high while armed or capturing
//
// Build option: define WAVE_CAP_TRIG_EN to start a capture only on an upward
// crossing of TRIG_LEVEL; when undefined the first valid sample after arming
// starts the capture (free-running).
module wave_capture #(
  parameter int         DEPTH      = 640,
  parameter logic [7:0] TRIG_LEVEL = 8'd128
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] sample_data,
  input  logic       sample_valid,
  input  logic       i_vs,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cap_done,
  output logic       busy
);

  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPT, FULL} state_t;

  state_t     state, state_nx;
  logic [9:0] wr_addr, wr_addr_nx;
  logic [7:0] prev_sample, prev_sample_nx;
  logic       wr_bank, wr_bank_nx;
  logic       disp_valid, disp_valid_nx;
  logic       cap_done_nx;
  logic       i_vs_d;
  logic       vs_rise;
  logic       level_cross;
  logic       trig_hit;
  logic       mem_we;
  logic [9:0] mem_waddr;
  logic       rd_ok;

  // Two banks of 1024 bytes; the bank bit is the top address bit.
  // Contents are deliberately not reset: disp_valid masks stale data.
  logic [7:0] mem [0:2047];

  assign vs_rise     = i_vs & ~i_vs_d;
  assign level_cross = (prev_sample < TRIG_LEVEL) && (sample_data >= TRIG_LEVEL);

`ifdef WAVE_CAP_TRIG_EN
  assign trig_hit = sample_valid && level_cross;
`else
  // Free-running: any valid sample starts the frame. The crossing detector is
  // left dangling in this build.
  logic trig_unused;
  assign trig_unused = level_cross;
  assign trig_hit    = sample_valid;
`endif

  assign busy  = (state == ARM) || (state == CAPT);
  assign rd_ok = disp_valid && (rd_addr <= LAST_ADDR);

  // Next-state and datapath control.
  always_comb begin
    state_nx       = state;
    wr_addr_nx     = wr_addr;
    prev_sample_nx = prev_sample;
    wr_bank_nx     = wr_bank;
    disp_valid_nx  = disp_valid;
    cap_done_nx    = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wr_addr;

    case (state)
      IDLE: begin
        state_nx       = ARM;
        prev_sample_nx = 8'hFF;
      end

      ARM: begin
        if (sample_valid) begin
          prev_sample_nx = sample_data;
        end
        if (trig_hit) begin
          // The triggering sample is the first stored sample.
          mem_we    = 1'b1;
          mem_waddr = 10'd0;
          if (LAST_ADDR == 10'd0) begin
            state_nx    = FULL;
            cap_done_nx = 1'b1;
          end else begin
            state_nx   = CAPT;
            wr_addr_nx = 10'd1;
          end
        end
      end

      CAPT: begin
        // i_vs edges are ignored here so the displayed bank never tears.
        if (sample_valid) begin
          prev_sample_nx = sample_data;
          mem_we         = 1'b1;
          mem_waddr      = wr_addr;
          if (wr_addr == LAST_ADDR) begin
            state_nx    = FULL;
            cap_done_nx = 1'b1;
          end else begin
            wr_addr_nx = wr_addr + 10'd1;
          end
        end
      end

      FULL: begin
        // Only a rise seen while already FULL swaps; a rise coinciding with
        // the final write was consumed in CAPT and waits for the next frame.
        if (vs_rise) begin
          wr_bank_nx     = ~wr_bank;
          disp_valid_nx  = 1'b1;
          wr_addr_nx     = 10'd0;
          prev_sample_nx = 8'hFF;
          state_nx       = ARM;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_addr     <= 10'd0;
      prev_sample <= 8'hFF;
      wr_bank     <= 1'b0;
      disp_valid  <= 1'b0;
      cap_done    <= 1'b0;
      i_vs_d      <= 1'b0;
      rd_data     <= 8'd0;
    end else begin
      state       <= state_nx;
      wr_addr     <= wr_addr_nx;
      prev_sample <= prev_sample_nx;
      wr_bank     <= wr_bank_nx;
      disp_valid  <= disp_valid_nx;
      cap_done    <= cap_done_nx;
      i_vs_d      <= i_vs;
      // The display bank is never written, so this read has no write hazard.
      rd_data     <= rd_ok ? mem[{~wr_bank, rd_addr}] : 8'd0;
    end
  end

  always_ff @(posedge pclk) begin
    if (mem_we) begin
      mem[{wr_bank, mem_waddr}] <= sample_data;
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: bench for wave_capture.
// Latency: outputs are sampled 1 ns after each rising pclk edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_wave_capture;

  localparam int         DEPTH = 640;
  localparam logic [7:0] TRIG  = 8'd128;

`ifdef WAVE_CAP_TRIG_EN
  localparam int DONE_EDGE = 128 + DEPTH - 1;
`else
  localparam int DONE_EDGE = DEPTH;
`endif

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_data = 8'd0;
  logic       sample_valid = 1'b0;
  logic       i_vs = 1'b0;
  logic [9:0] rd_addr = 10'd0;
  logic [7:0] rd_data;
  logic       cap_done;
  logic       busy;

  wave_capture #(.DEPTH(DEPTH), .TRIG_LEVEL(TRIG)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .i_vs        (i_vs),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .cap_done    (cap_done),
    .busy        (busy)
  );

  always #20 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int ramp_n = 0;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t tbl[6];

  // Reference model: a frame is a queue of accepted samples; the display is
  // a copy of the last completed frame.
  bit          m_started;
  bit          m_full;
  bit          m_disp_ok;
  int          m_prev;
  bit          m_vs_prev;
  byte unsigned cap_q[$];
  byte unsigned m_disp[1024];
  int          exp_rd;
  int          exp_done;
  int          exp_busy;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit fires(input int prev, input int cur);
`ifdef WAVE_CAP_TRIG_EN
    return (prev < int'(TRIG)) && (cur >= int'(TRIG));
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_full    = 0;
    m_disp_ok = 0;
    m_prev    = 255;
    m_vs_prev = 0;
    cap_q.delete();
    exp_rd   = 0;
    exp_done = 0;
    exp_busy = 0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step(input bit rst, input bit sv, input int sd,
                            input bit vs, input int ra);
    if (!rst) begin
      model_reset();
      return;
    end
    exp_rd   = (m_disp_ok && ra < DEPTH) ? int'(m_disp[ra]) : 0;
    exp_done = 0;
    if (!m_started) begin
      m_started = 1;
      m_prev    = 255;
    end else if (m_full) begin
      if (vs && !m_vs_prev) begin
        foreach (cap_q[i]) m_disp[i] = cap_q[i];
        m_disp_ok = 1;
        cap_q.delete();
        m_full = 0;
        m_prev = 255;
      end
    end else if (sv) begin
      if (cap_q.size() > 0 || fires(m_prev, sd)) cap_q.push_back(byte'(sd));
      m_prev = sd;
      if (cap_q.size() == DEPTH) begin
        m_full   = 1;
        exp_done = 1;
      end
    end
    m_vs_prev = vs;
    exp_busy  = (m_started && !m_full) ? 1 : 0;
  endtask

  task automatic cycle();
    model_step(rst_n, sample_valid, int'(sample_data), i_vs, int'(rd_addr));
    @(posedge pclk);
    #1;
    check("rd_data", int'(rd_data), exp_rd);
    check("cap_done", int'(cap_done), exp_done);
    check("busy", int'(busy), exp_busy);
  endtask

  task automatic ramp_cycle();
    sample_data = 8'(ramp_n);
    ramp_n++;
    cycle();
  endtask

  // Drop reset between edges, verify the outputs clear at once, then release.
  task automatic async_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_rd"}, int'(rd_data), 0);
    check({name, "_done"}, int'(cap_done), 0);
    check({name, "_busy"}, int'(busy), 0);
    model_reset();
    cycle();
    cycle();
    #5;
    rst_n  = 1'b1;
    ramp_n = 0;
  endtask

  initial begin
    int  done_at;
    bit  found;
    bit  saw_done;
    int  vs_timer;

`ifdef WAVE_CAP_TRIG_EN
    tbl[0] = '{10'd0,    8'd128};
    tbl[1] = '{10'd5,    8'd133};
    tbl[2] = '{10'd639,  8'd255};
`else
    tbl[0] = '{10'd0,    8'd1};
    tbl[1] = '{10'd5,    8'd6};
    tbl[2] = '{10'd639,  8'd128};
`endif
    tbl[3] = '{10'd640,  8'd0};
    tbl[4] = '{10'd700,  8'd0};
    tbl[5] = '{10'd1023, 8'd0};

    // Reset state.
    model_reset();
    sample_valid = 1'b1;
    #5;
    check("reset_rd", int'(rd_data), 0);
    check("reset_done", int'(cap_done), 0);
    check("reset_busy", int'(busy), 0);
    #10;
    rst_n = 1'b1;

    // Ramp capture from reset release.
    done_at = -1;
    for (int n = 0; n < 2000 && done_at < 0; n++) begin
      ramp_cycle();
      if (cap_done) begin
        done_at = n;
        check("busy_in_full", int'(busy), 0);
      end
    end
    check("cap_done_edge", done_at, DONE_EDGE);

    // Swap on i_vs rise, then read back the table.
    i_vs = 1'b1;
    ramp_cycle();
    for (int i = 0; i < 6; i++) begin
      rd_addr = tbl[i].addr;
      ramp_cycle();
      check($sformatf("tbl_addr%0d", tbl[i].addr), int'(rd_data), int'(tbl[i].exp));
    end

    // Display held while the next frame is armed/captured across 3 vsyncs.
    rd_addr = 10'd5;
    for (int f = 0; f < 3; f++) begin
      i_vs = 1'b0;
      for (int k = 0; k < 60; k++) ramp_cycle();
      i_vs = 1'b1;
      for (int k = 0; k < 4; k++) ramp_cycle();
      check("hold_addr5", int'(rd_data), int'(tbl[1].exp));
    end
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      ramp_cycle();
      if (cap_done) found = 1;
    end
    check("second_frame_done", int'(found), 1);
    i_vs = 1'b0;
    ramp_cycle();
    i_vs = 1'b1;
    ramp_cycle();
    ramp_cycle();

    // Reset at address 300 of a capture.
    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      ramp_cycle();
      if (cap_q.size() == 300) found = 1;
    end
    check("reached_addr300", int'(found), 1);
    i_vs = 1'b0;
    async_reset("rst_mid_capt");
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      rd_addr = 10'($urandom_range(0, 1023));
      ramp_cycle();
      if (cap_done) found = 1;
    end
    check("recapture_done", int'(found), 1);
    rd_addr = 10'd0;
    ramp_cycle();
    check("no_disp_before_swap", int'(rd_data), 0);
    i_vs = 1'b1;
    ramp_cycle();
    ramp_cycle();
    check("after_reset_swap_addr0", int'(rd_data), int'(tbl[0].exp));

    // Constant 200 input.
    i_vs = 1'b0;
    async_reset("rst_const");
    sample_data  = 8'd200;
    sample_valid = 1'b1;
`ifdef WAVE_CAP_TRIG_EN
    rd_addr  = 10'd10;
    saw_done = 0;
    for (int k = 0; k < 1500; k++) begin
      i_vs = ((k % 200) > 190);
      cycle();
      if (cap_done) saw_done = 1;
    end
    check("const_no_done", int'(saw_done), 0);
    check("const_busy", int'(busy), 1);
    check("const_rd_zero", int'(rd_data), 0);
`else
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      cycle();
      if (cap_done) found = 1;
    end
    check("const_done", int'(found), 1);
    i_vs = 1'b1;
    cycle();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 10'(a);
      cycle();
      check("const_rd", int'(rd_data), 200);
    end
`endif

    // Randomized traffic against the model.
    i_vs = 1'b0;
    async_reset("rst_rand");
    vs_timer = $urandom_range(100, 900);
    for (int k = 0; k < 20000; k++) begin
      sample_valid = ($urandom_range(0, 9) < 7);
      sample_data  = 8'($urandom);
      rd_addr      = 10'($urandom_range(0, 1023));
      vs_timer--;
      i_vs = (vs_timer < 3);
      if (vs_timer == 0) vs_timer = $urandom_range(100, 900);
      if (k == 10000) begin
        async_reset("rst_rand_mid");
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 640, number of samples per captured frame (one per displayed pixel column).
REQ-002 SHALL have parameter TRIG_LEVEL, default 8'd128, the trigger threshold on the 8-bit sample.
REQ-003 SHALL have port pclk  input  1  pixel clock (25 MHz), the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_data  input  8  waveform sample (DDS output, already in pclk domain).
REQ-006 SHALL have port sample_valid  input  1  qualifies sample_data for one cycle.
REQ-007 SHALL have port i_vs  input  1  vertical sync from the display timing chain, active-high.
REQ-008 SHALL have port rd_addr  input  10  display read column.
REQ-009 SHALL have port rd_data  output  8  sample at rd_addr from the display bank, feeds the waveform overlay's dac_buf_data.
REQ-010 SHALL have port cap_done  output  1  one-cycle pulse when a capture bank fills.
REQ-011 SHALL have port busy  output  1  high while in ARM or CAPT.

Function
REQ-012 SHALL hold two banks of 1024x8 storage (ping-pong): write bank and display bank, selected by internal bit wr_bank; display bank = ~wr_bank.
REQ-013 SHALL implement states IDLE, ARM, CAPT, FULL.
REQ-014 SHALL move IDLE -> ARM unconditionally on the first cycle after reset release.
REQ-015 SHALL, in ARM, detect trigger on a valid sample where the previous valid sample < TRIG_LEVEL and the current valid sample >= TRIG_LEVEL; go to CAPT on that cycle.
REQ-016 SHALL write the triggering sample at write address 0 and each later valid sample at the next address.
REQ-017 SHALL ignore cycles with sample_valid low; the write address and the previous-sample register hold.
REQ-018 SHALL enter FULL on the cycle the sample at address DEPTH-1 is written, and pulse cap_done high that same cycle.
REQ-019 SHALL detect the i_vs rising edge by one register stage (edge = i_vs & ~i_vs_d).
REQ-020 SHALL, in FULL on an i_vs rising edge, toggle wr_bank, set disp_valid, reset the write address to 0, and return to ARM.
REQ-021 SHALL ignore i_vs edges in ARM and CAPT; the display bank stays unchanged, so the display never tears.
REQ-022 SHALL not act on an i_vs edge in the same cycle as the final write; the swap waits for the next edge.
REQ-023 SHALL return rd_data one cycle after rd_addr (registered read) from the display bank.
REQ-024 SHALL drive rd_data = 0 when rd_addr >= DEPTH or disp_valid = 0.
REQ-025 SHALL seed the previous-sample register to 8'hFF on entering ARM, so a sample already above threshold does not trigger.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set state=IDLE, wr_bank=0, disp_valid=0, write address=0, previous sample=8'hFF, i_vs_d=0, rd_data=0, cap_done=0, busy=0.
REQ-027 SHALL not clear storage contents on reset; disp_valid masks them.
REQ-028 SHALL, on reset mid-capture, discard the partial capture and restart from IDLE.

Configuration
REQ-029 SHALL honour macro WAVE_CAP_TRIG_EN: when defined, the trigger follows REQ-015; when undefined, ARM goes to CAPT on the first valid sample, which is written at address 0 (free-running capture).

Verification
REQ-030 SHALL verify reset release with ramp 0..255 on every cycle at TRIG_LEVEL=128 -> sample 128 stored at address 0, cap_done after 640 valid samples, busy low in FULL.
REQ-031 SHALL verify FULL followed by an i_vs rise -> next-but-one cycle rd_addr=0 gives rd_data=128, rd_addr=5 gives 133, rd_addr=700 gives 0.
REQ-032 SHALL verify the display bank is held constant while ARM/CAPT take i_vs edges -> rd_data unchanged across 3 frames until the next swap.
REQ-033 SHALL verify a constant input of 200 with the trigger macro defined -> never leaves ARM, cap_done never pulses, rd_data stays 0.
REQ-034 SHALL verify constant 200 with the macro undefined -> capture completes, and after the swap every address 0..639 reads 200.
REQ-035 SHALL verify rst_n pulled low at address 300 of CAPT -> all outputs 0 immediately, and disp_valid=0 so rd_data=0 until a full new capture plus swap.
